// File: rtl/cam_init_sequencer.sv
// cam_init_sequencer: camera power-up and SCCB register-table walker.
// Holds the sensor in reset, waits for boot, then reads {reg_addr, data}
// entries from a synchronous ROM and issues one write request per entry.
// Entry 16'hFFFF ends the table; reg_addr 8'hFF with data N is an N-unit delay.
// Optional build macro CAM_INIT_RETRY_EN: retry a NACKed write up to
// MAX_RETRIES extra times before flagging an error (default: no retries).
// Handshake: a request transfers on the rising clk edge where req_valid_o and
// req_ready_i are both 1; the fields stay stable while req_valid_o is 1, and
// req_valid_o is low in the cycle after the transfer. resp_valid_i is a
// single-cycle pulse qualified by resp_nack_i and is only acted on in WAIT_RESP.
// dbg_state_o exposes the FSM state encoding for observation.
module cam_init_sequencer #(
    parameter logic [7:0]  DEVICE_ADDR       = 8'h42,
    parameter int unsigned ROM_AW            = 8,
    parameter int unsigned RESET_HOLD_CYCLES = 1_000_000,
    parameter int unsigned BOOT_WAIT_CYCLES  = 5_000_000,
    parameter int unsigned WRITE_GAP_CYCLES  = 1000,
    parameter int unsigned DELAY_UNIT_CYCLES = 100_000,
    parameter int unsigned MAX_RETRIES       = 3
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [7:0]        req_dev_addr_o,
    output logic [7:0]        req_reg_addr_o,
    output logic [7:0]        req_data_o,
    input  logic              resp_valid_i,
    input  logic              resp_nack_i,
    output logic              reset_cmos_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ROM_AW-1:0] err_index_o,
    output logic [3:0]        dbg_state_o
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RST_CAM   = 4'd1,
        ST_BOOT      = 4'd2,
        ST_FETCH     = 4'd3,
        ST_DECODE    = 4'd4,
        ST_ISSUE     = 4'd5,
        ST_WAIT_RESP = 4'd6,
        ST_GAP       = 4'd7,
        ST_DELAY     = 4'd8,
        ST_DONE      = 4'd9,
        ST_ERROR     = 4'd10
    } state_e;

    // One down-counter serves every wait; it is loaded with (cycles - 1).
    localparam int unsigned DELAY_MAX = 255 * DELAY_UNIT_CYCLES;
    localparam int unsigned MAX_AB    = (RESET_HOLD_CYCLES > BOOT_WAIT_CYCLES) ? RESET_HOLD_CYCLES : BOOT_WAIT_CYCLES;
    localparam int unsigned MAX_CD    = (WRITE_GAP_CYCLES > DELAY_MAX) ? WRITE_GAP_CYCLES : DELAY_MAX;
    localparam int unsigned MAX_WAIT  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W     = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    localparam logic [ROM_AW-1:0] IDX_ONE  = 1;
    localparam logic [ROM_AW-1:0] IDX_LAST = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

    state_e            state_q, state_d;
    logic [ROM_AW-1:0] index_q, index_d;
    logic [ROM_AW-1:0] err_index_q, err_index_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        dev_q, dev_d, reg_q, reg_d, data_q, data_d;
    logic              valid_q, valid_d, cmos_q, cmos_d;
    logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic              adv;
    logic [31:0]       delay_cycles;

    assign delay_cycles = 32'(rom_data_i[7:0]) * DELAY_UNIT_CYCLES;

`ifdef CAM_INIT_RETRY_EN
    localparam int unsigned RTY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    logic [RTY_W-1:0] retry_q, retry_d;

    // Per-entry retry count, cleared when each entry is decoded.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) retry_q <= '0;
        else            retry_q <= retry_d;
    end
`else
    logic [31:0] unused_max_retries;
    assign unused_max_retries = MAX_RETRIES;
`endif

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        err_index_d = err_index_q;
        cnt_d       = cnt_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        data_d      = data_q;
        cmos_d      = cmos_q;
        error_d     = error_q;
        adv         = 1'b0;
`ifdef CAM_INIT_RETRY_EN
        retry_d     = retry_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    index_d     = '0;
                    err_index_d = '0;
                    error_d     = 1'b0;
                    if (RESET_HOLD_CYCLES != 0) begin
                        state_d = ST_RST_CAM;
                        cnt_d   = CNT_W'(RESET_HOLD_CYCLES - 1);
                        cmos_d  = 1'b0;
                    end else if (BOOT_WAIT_CYCLES != 0) begin
                        state_d = ST_BOOT;
                        cnt_d   = CNT_W'(BOOT_WAIT_CYCLES - 1);
                        cmos_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        cmos_d  = 1'b1;
                    end
                end
            end
            ST_RST_CAM: begin
                if (cnt_q == '0) begin
                    cmos_d = 1'b1;
                    if (BOOT_WAIT_CYCLES != 0) begin
                        state_d = ST_BOOT;
                        cnt_d   = CNT_W'(BOOT_WAIT_CYCLES - 1);
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_BOOT: begin
                if (cnt_q == '0) state_d = ST_FETCH;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                dev_d  = DEVICE_ADDR;
                reg_d  = rom_data_i[15:8];
                data_d = rom_data_i[7:0];
`ifdef CAM_INIT_RETRY_EN
                retry_d = '0;
`endif
                if (rom_data_i == 16'hFFFF) begin
                    state_d = ST_DONE;
                end else if (rom_data_i[15:8] == 8'hFF) begin
                    if (rom_data_i[7:0] == 8'h00) begin
                        adv = 1'b1;
                    end else begin
                        state_d = ST_DELAY;
                        cnt_d   = CNT_W'(delay_cycles - 32'd1);
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (req_ready_i) state_d = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (resp_valid_i) begin
                    if (!resp_nack_i) begin
                        if (WRITE_GAP_CYCLES != 0) begin
                            state_d = ST_GAP;
                            cnt_d   = CNT_W'(WRITE_GAP_CYCLES - 1);
                        end else begin
                            adv = 1'b1;
                        end
`ifdef CAM_INIT_RETRY_EN
                    end else if (32'(retry_q) < MAX_RETRIES) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_ISSUE;
`endif
                    end else begin
                        state_d     = ST_ERROR;
                        error_d     = 1'b1;
                        err_index_d = index_q;
                    end
                end
            end
            ST_GAP, ST_DELAY: begin
                if (cnt_q == '0) adv   = 1'b1;
                else             cnt_d = cnt_q - CNT_ONE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Step to the next entry; the index stops at the last table slot.
        if (adv) begin
            if (index_q == IDX_LAST) begin
                state_d = ST_DONE;
            end else begin
                index_d = index_q + IDX_ONE;
                state_d = ST_FETCH;
            end
        end

        valid_d = (state_d == ST_ISSUE);
        busy_d  = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERROR));
        done_d  = (state_d == ST_DONE);
    end

    // Datapath and status registers; outputs come straight from these.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            index_q     <= '0;
            err_index_q <= '0;
            cnt_q       <= '0;
            dev_q       <= '0;
            reg_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            cmos_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            index_q     <= index_d;
            err_index_q <= err_index_d;
            cnt_q       <= cnt_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            cmos_q      <= cmos_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign rom_addr_o     = index_q;
    assign req_valid_o    = valid_q;
    assign req_dev_addr_o = dev_q;
    assign req_reg_addr_o = reg_q;
    assign req_data_o     = data_q;
    assign reset_cmos_o   = cmos_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign err_index_o    = err_index_q;
    assign dbg_state_o    = state_q;

endmodule
